// File: rtl/wall_renderer.sv
// Wall strip renderer: turns a wall position and hole row into column-major VGA pixel writes.
// Define WALL_RENDERER_ERASE_EN to erase the previously drawn strip before each redraw.
module wall_renderer #(
  parameter int         WALL_WIDTH  = 4,
  parameter int         HOLE_HEIGHT = 50,
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120,
  parameter logic [2:0] WALL_COLOUR = 3'b010,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] wall_x,
  input  logic [7:0] hole_y,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int          CW       = (WALL_WIDTH > 1) ? $clog2(WALL_WIDTH) : 1;
  localparam logic [8:0]  SW9      = 9'(SCREEN_W);
  localparam logic [8:0]  HOLE9    = 9'(HOLE_HEIGHT);
  localparam logic [6:0]  ROW_LAST = 7'(SCREEN_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WALL_WIDTH - 1);

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
  } pix_t;

`ifdef WALL_RENDERER_ERASE_EN
  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
`endif

  state_t        state;
  logic [7:0]    new_x;
  logic [7:0]    new_hole;
  logic [CW-1:0] col;
  logic [6:0]    row;
  pix_t          px;
`ifdef WALL_RENDERER_ERASE_EN
  logic [7:0]    old_x;
  logic          drawn_valid;
`endif

  // Column sum and hole bound are 9 bits wide so neither clipping nor the hole test can wrap.
  function automatic pix_t mk_pix(input logic [7:0] base, input logic [CW-1:0] c,
                                  input logic [6:0] r, input logic is_draw,
                                  input logic [7:0] hole);
    logic [8:0] sum;
    logic [8:0] r9;
    logic [8:0] lo;
    logic       in_hole;
    pix_t       p;
    sum     = {1'b0, base} + 9'(c);
    r9      = {2'b00, r};
    lo      = {1'b0, hole};
    in_hole = (r9 >= lo) && (r9 < lo + HOLE9);
    p.x      = sum[7:0];
    p.y      = r;
    p.plot   = (sum < SW9);
    p.colour = (is_draw && !in_hole) ? WALL_COLOUR : BG_COLOUR;
    return p;
  endfunction

  logic          row_end;
  logic          last;
  logic [CW-1:0] col_n;
  logic [6:0]    row_n;

  always_comb begin
    row_end = (row == ROW_LAST);
    last    = row_end && (col == COL_LAST);
    row_n   = row_end ? 7'd0 : row + 7'd1;
    col_n   = row_end ? col + CW'(1) : col;
  end

  // The pixel for the state being entered is registered on the same edge, so plot
  // rises the cycle after start is accepted and passes run back to back.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      new_x       <= '0;
      new_hole    <= '0;
      col         <= '0;
      row         <= '0;
      px          <= '{x: 8'd0, y: 7'd0, colour: BG_COLOUR, plot: 1'b0};
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef WALL_RENDERER_ERASE_EN
      old_x       <= '0;
      drawn_valid <= 1'b0;
`endif
    end else begin
      done    <= 1'b0;
      px.plot <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            new_x    <= wall_x;
            new_hole <= hole_y;
            col      <= '0;
            row      <= '0;
            busy     <= 1'b1;
`ifdef WALL_RENDERER_ERASE_EN
            if (drawn_valid) begin
              state <= ERASE;
              px    <= mk_pix(old_x, '0, 7'd0, 1'b0, hole_y);
            end else
`endif
            begin
              state <= DRAW;
              px    <= mk_pix(wall_x, '0, 7'd0, 1'b1, hole_y);
            end
          end
        end
`ifdef WALL_RENDERER_ERASE_EN
        ERASE: begin
          if (last) begin
            col   <= '0;
            row   <= '0;
            state <= DRAW;
            px    <= mk_pix(new_x, '0, 7'd0, 1'b1, new_hole);
          end else begin
            col <= col_n;
            row <= row_n;
            px  <= mk_pix(old_x, col_n, row_n, 1'b0, new_hole);
          end
        end
`endif
        DRAW: begin
          if (last) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            col <= col_n;
            row <= row_n;
            px  <= mk_pix(new_x, col_n, row_n, 1'b1, new_hole);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
`ifdef WALL_RENDERER_ERASE_EN
          old_x       <= new_x;
          drawn_valid <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign x      = px.x;
  assign y      = px.y;
  assign colour = px.colour;
  assign plot   = px.plot;

endmodule

// File: tb/tb_wall_renderer.sv
// Scoreboard bench for wall_renderer: stimulus queues expected pixels, a monitor pops them on plot.
module tb_wall_renderer;

  localparam logic [2:0] WALL = 3'b010;
  localparam logic [2:0] BG   = 3'b000;
`ifdef WALL_RENDERER_ERASE_EN
  localparam bit ER = 1'b1;
`else
  localparam bit ER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] wall_x;
  logic [7:0] hole_y;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  wall_renderer dut (
    .clk(clk), .reset(reset), .start(start), .wall_x(wall_x), .hole_y(hole_y),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  int n_plot = 0;
  int n_bg   = 0;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Monitor: every plotted pixel must match the head of the scoreboard queue.
  always begin : mon
    exp_t e;
    @(posedge clk);
    #1;
    if (plot) begin
      n_plot++;
      if (colour == BG) n_bg++;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_plot got x=%0d y=%0d c=%0d expected no plot", x, y, colour);
      end else begin
        e = sbq.pop_front();
        if (x !== e.x || y !== e.y || colour !== e.c) begin
          errors++;
          $display("FAIL pixel got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                   x, y, colour, e.x, e.y, e.c);
        end
      end
    end
  end

  // Expected plotted pixels of one pass, column-major, clipped at column 160.
  task automatic push_pass(input int base, input int hole, input bit is_draw);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 120; r++) begin
        if (base + c < 160) begin
          exp_t e;
          e.x = 8'(base + c);
          e.y = 7'(r);
          e.c = (is_draw && !(r >= hole && r < hole + 50)) ? WALL : BG;
          sbq.push_back(e);
        end
      end
    end
  endtask

  task automatic redraw(input int wx, input int hy, input int old, input bit erase,
                        input int ep, input int eb, input int el, input int ign);
    int p0, b0, acc;
    bit got, pulsed;
    p0 = n_plot;
    b0 = n_bg;
    if (erase) push_pass(old, 0, 1'b0);
    push_pass(wx, hy, 1'b1);
    @(negedge clk);
    wall_x = 8'(wx);
    hole_y = 8'(hy);
    start  = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    chk("busy_running", busy, 1);
    chk("first_plot", plot, 1);
    @(negedge clk);
    start = 1'b0;
    got    = 1'b0;
    pulsed = 1'b0;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(posedge clk);
      #1;
      if (done) got = 1'b1;
      else if (ign > 0 && !pulsed && n_plot - p0 >= ign) begin
        pulsed = 1'b1;
        wall_x = 8'd200;
        hole_y = 8'd0;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    chk("done_seen", got, 1);
    if (got) chk("done_latency", cyc - acc + 1, el);
    chk("plot_count", n_plot - p0, ep);
    chk("bg_count", n_bg - b0, eb);
    chk("queue_left", sbq.size(), 0);
    @(posedge clk);
    #1;
    chk("done_pulse_width", done, 0);
    chk("busy_after_done", busy, 0);
    sbq.delete();
  endtask

  initial begin
    int p0;
    bit hit;
    reset  = 1'b1;
    start  = 1'b0;
    wall_x = 8'd0;
    hole_y = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_x", x, 0);
    chk("reset_y", y, 0);
    chk("reset_colour", colour, BG);
    chk("reset_plot", plot, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    @(negedge clk);
    reset = 1'b0;

    // first draw after reset: hole rows 30..79
    redraw(100, 30, 0, 1'b0, 480, 200, 481, 0);
    // second redraw erases x 100..103 when erase is built in
    redraw(88, 10, 100, ER, ER ? 960 : 480, ER ? 680 : 200, ER ? 961 : 481, 0);
    // right-edge clip: only columns 158,159 plotted in the draw pass
    redraw(158, 40, 88, ER, ER ? 720 : 240, ER ? 580 : 100, ER ? 961 : 481, 0);
    // hole past the bottom: rows 100..119 background, no wrap
    redraw(20, 100, 158, ER, ER ? 720 : 480, ER ? 320 : 80, ER ? 961 : 481, 0);
    // start pulsed mid-pass must be ignored
    redraw(10, 5, 20, ER, ER ? 960 : 480, ER ? 680 : 200, ER ? 961 : 481, 50);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("idle_after_ignored_start", busy, 0);
    end

    // reset in the middle of a pass
    p0 = n_plot;
    if (ER) push_pass(10, 0, 1'b0);
    push_pass(30, 20, 1'b1);
    @(negedge clk);
    wall_x = 8'd30;
    hole_y = 8'd20;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 1000 && !hit; k++) begin
      @(negedge clk);
      if (n_plot - p0 >= 200) hit = 1'b1;
    end
    chk("reached_pixel_200", hit, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_plot", plot, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    sbq.delete();
    @(negedge clk);
    reset = 1'b0;

    // after a mid-pass reset the next redraw is draw-only
    redraw(40, 0, 0, 1'b0, 480, 200, 481, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
